qpsk_symbol_scheduler: RTL and testbench

- Frame sequencer in front of the QPSK mapper.
- Accepts a serial payload bitstream over a valid/ready handshake and pairs the bits into dibits.
- Builds each frame as: preamble symbols, then data symbols with a pilot symbol inserted periodically.
- Presents one (bit1, bit2) symbol per handshake to the mapper stage, together with sym_valid, sym_ready and a pilot flag.

---
 rtl/qpsk_symbol_scheduler_if.sv | 22 ++
 rtl/qpsk_symbol_scheduler.sv | 140 ++++++++++++++
 tb/tb_qpsk_symbol_scheduler.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/qpsk_symbol_scheduler_if.sv
// Payload-bit and mapper-symbol handshakes for the QPSK frame sequencer.
// slave is the sequencer's view; master is the neighbouring stages' view.
interface qpsk_symbol_scheduler_if;
  logic in_bit;
  logic in_valid;
  logic in_ready;
  logic sym_bit1;
  logic sym_bit2;
  logic sym_valid;
  logic sym_ready;
  logic sym_is_pilot;

  modport master (
    output in_bit, in_valid, sym_ready,
    input  in_ready, sym_bit1, sym_bit2, sym_valid, sym_is_pilot
  );

  modport slave (
    input  in_bit, in_valid, sym_ready,
    output in_ready, sym_bit1, sym_bit2, sym_valid, sym_is_pilot
  );
endinterface

// File: rtl/qpsk_symbol_scheduler.sv
// Frame sequencer ahead of the QPSK mapper: preamble, then payload dibits
// with periodic pilots, delivered through a single-entry output register.
module qpsk_symbol_scheduler #(
  parameter int unsigned PREAMBLE_LEN = 4,
  parameter int unsigned FRAME_SYMS   = 32,
  parameter int unsigned PILOT_PERIOD = 8,
  parameter int unsigned CNT_W        = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  qpsk_symbol_scheduler_if.slave      bus,
  output logic                        busy,
  output logic                        frame_done
);
  typedef enum logic [2:0] {IDLE, PREAMBLE, DATA, PILOT, DRAIN} state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] p_cnt, p_cnt_n;
  logic [CNT_W-1:0] d_cnt, d_cnt_n;
  logic [CNT_W-1:0] pc_cnt, pc_cnt_n;
  logic             have_first, have_first_n;
  logic             first_bit, first_bit_n;
  logic             out_b1, out_b2, out_pilot, out_valid;
  logic             load, load_b1, load_b2, load_pilot;
  logic             load_ok, accept;

  assign load_ok = !out_valid || bus.sym_ready;

  always_comb begin
    state_n      = state;
    p_cnt_n      = p_cnt;
    d_cnt_n      = d_cnt;
    pc_cnt_n     = pc_cnt;
    have_first_n = have_first;
    first_bit_n  = first_bit;
    load         = 1'b0;
    load_b1      = 1'b0;
    load_b2      = 1'b0;
    load_pilot   = 1'b0;
    accept       = 1'b0;
    frame_done   = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_n      = PREAMBLE;
          p_cnt_n      = '0;
          d_cnt_n      = '0;
          pc_cnt_n     = '0;
          have_first_n = 1'b0;
        end
      end
      PREAMBLE: begin
        if (load_ok) begin
          load       = 1'b1;
          load_b1    = p_cnt[0];
          load_b2    = p_cnt[0];
          load_pilot = 1'b1;
          p_cnt_n    = p_cnt + 1'b1;
          if (p_cnt == CNT_W'(PREAMBLE_LEN - 1)) state_n = DATA;
        end
      end
      DATA: begin
        // The first bit of a pair can always be parked; the second needs room.
        accept = !have_first || load_ok;
        if (bus.in_valid && accept) begin
          if (!have_first) begin
            first_bit_n  = bus.in_bit;
            have_first_n = 1'b1;
          end else begin
            load         = 1'b1;
            load_b1      = first_bit;
            load_b2      = bus.in_bit;
            have_first_n = 1'b0;
            d_cnt_n      = d_cnt + 1'b1;
            if (d_cnt == CNT_W'(FRAME_SYMS - 1)) begin
              state_n = DRAIN;
            end else if (pc_cnt == CNT_W'(PILOT_PERIOD - 1)) begin
              state_n  = PILOT;
              pc_cnt_n = '0;
            end else begin
              pc_cnt_n = pc_cnt + 1'b1;
            end
          end
        end
      end
      PILOT: begin
        if (load_ok) begin
          load       = 1'b1;
          load_pilot = 1'b1;
          state_n    = DATA;
        end
      end
      DRAIN: begin
        if (!out_valid || bus.sym_ready) begin
          frame_done = 1'b1;
          state_n    = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      p_cnt      <= '0;
      d_cnt      <= '0;
      pc_cnt     <= '0;
      have_first <= 1'b0;
      first_bit  <= 1'b0;
      out_b1     <= 1'b0;
      out_b2     <= 1'b0;
      out_pilot  <= 1'b0;
      out_valid  <= 1'b0;
    end else begin
      state      <= state_n;
      p_cnt      <= p_cnt_n;
      d_cnt      <= d_cnt_n;
      pc_cnt     <= pc_cnt_n;
      have_first <= have_first_n;
      first_bit  <= first_bit_n;
      if (load) begin
        out_b1    <= load_b1;
        out_b2    <= load_b2;
        out_pilot <= load_pilot;
        out_valid <= 1'b1;
      end else if (bus.sym_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign bus.in_ready     = accept;
  assign bus.sym_bit1     = out_b1;
  assign bus.sym_bit2     = out_b2;
  assign bus.sym_is_pilot = out_pilot;
  assign bus.sym_valid    = out_valid;
  assign busy             = (state != IDLE);
endmodule

// File: tb/tb_qpsk_symbol_scheduler.sv
// Bench for qpsk_symbol_scheduler: a frame-level model predicts the symbol
// stream from accepted payload bits; literal checks pin the model per scenario.
`timescale 1ns/1ps
module tb_qpsk_symbol_scheduler;
  localparam int PP = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, start0, start1, busy0, busy1, fd0, fd1;
  logic d_bit, d_valid, d_ready, sel;

  qpsk_symbol_scheduler_if b0();
  qpsk_symbol_scheduler_if b1();

  assign b0.in_bit    = d_bit;
  assign b0.in_valid  = d_valid;
  assign b0.sym_ready = d_ready;
  assign b1.in_bit    = d_bit;
  assign b1.in_valid  = d_valid;
  assign b1.sym_ready = d_ready;

  qpsk_symbol_scheduler #(.PREAMBLE_LEN(4), .FRAME_SYMS(32), .PILOT_PERIOD(8), .CNT_W(8)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .bus(b0), .busy(busy0), .frame_done(fd0)
  );
  qpsk_symbol_scheduler #(.PREAMBLE_LEN(4), .FRAME_SYMS(16), .PILOT_PERIOD(8), .CNT_W(8)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .bus(b1), .busy(busy1), .frame_done(fd1)
  );

  logic m_bit, m_vin, m_rdy_in, m_b1, m_b2, m_sv, m_pil, m_busy, m_fd, m_start;
  assign m_bit    = sel ? b1.in_bit       : b0.in_bit;
  assign m_vin    = sel ? b1.in_valid     : b0.in_valid;
  assign m_rdy_in = sel ? b1.in_ready     : b0.in_ready;
  assign m_b1     = sel ? b1.sym_bit1     : b0.sym_bit1;
  assign m_b2     = sel ? b1.sym_bit2     : b0.sym_bit2;
  assign m_sv     = sel ? b1.sym_valid    : b0.sym_valid;
  assign m_pil    = sel ? b1.sym_is_pilot : b0.sym_is_pilot;
  assign m_busy   = sel ? busy1           : busy0;
  assign m_fd     = sel ? fd1             : fd0;
  assign m_start  = sel ? start1          : start0;

  int n_cmp = 0;
  int n_bad = 0;

  // Model state: expected symbols as {bit1, bit2, pilot}.
  logic [2:0] exp_q[$];
  logic [2:0] out_log[64];
  logic [2:0] nom_log[64];
  logic [2:0] s_now, prev_sym;
  int sym_count, bits_acc, dcount, data_out, fd_count, frame_f;
  logic half, half_bit, active, prev_hold;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        half = 1'b0; active = 1'b0; prev_hold = 1'b0;
      end else begin
        s_now = {m_b1, m_b2, m_pil};
        check("busy", m_busy, active);
        if (!active) check("idle_sym_valid", m_sv, 0);
        if (prev_hold) begin
          check("hold_valid", m_sv, 1);
          check("hold_sym", s_now, prev_sym);
        end
        if (m_vin && m_rdy_in) begin
          bits_acc++;
          if (half) begin
            exp_q.push_back({half_bit, m_bit, 1'b0});
            dcount++;
            if ((dcount % PP) == 0 && dcount < frame_f) exp_q.push_back(3'b001);
            half = 1'b0;
          end else begin
            half_bit = m_bit;
            half     = 1'b1;
          end
        end
        if (m_sv && d_ready) begin
          if (exp_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL sym_extra: got symbol %b expected none (t=%0t)", s_now, $time);
          end else begin
            check("sym", s_now, exp_q.pop_front());
          end
          if (sym_count < 64) out_log[sym_count] = s_now;
          sym_count++;
          if (!m_pil) data_out++;
        end
        if (m_fd) begin
          fd_count++;
          check("fd_while_active", active, 1);
          check("fd_queue_empty", exp_q.size(), 0);
          check("fd_data_count", dcount, frame_f);
          check("fd_half_empty", half, 0);
          active = 1'b0;
        end
        if (m_start) active = 1'b1;
        prev_hold = m_sv && !d_ready;
        prev_sym  = s_now;
      end
    end
  endtask

  // Caller must be at posedge+1; start is driven in that same cycle.
  task automatic begin_frame(input logic s, input int f);
    d_valid = 1'b0; d_ready = 1'b1; sel = s; frame_f = f;
    sym_count = 0; bits_acc = 0; dcount = 0; data_out = 0; fd_count = 0; half = 1'b0;
    exp_q.delete();
    for (int k = 0; k < 4; k++) exp_q.push_back({k[0], k[0], 1'b1});
    if (s) start1 = 1'b1; else start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0; start1 = 1'b0;
  endtask

  task automatic run_frame(input logic s, input int f, input int bmode, input int vper,
                           input int stall_at, input int abort_bits);
    int cyc;
    int stall_n;
    logic [7:0] pat;
    pat = 8'b1011_0010; cyc = 0; stall_n = 0;
    begin_frame(s, f);
    while (fd_count == 0 && cyc < 3000) begin
      d_valid = ((cyc % vper) == 0) && (abort_bits < 0 || bits_acc < abort_bits);
      d_bit   = (bmode == 0) ? ~bits_acc[0] : pat[bits_acc % 8];
      if (stall_at >= 0 && sym_count >= stall_at && stall_n < 5) begin
        d_ready = 1'b0;
        stall_n++;
        if (stall_n == 5) begin
          @(negedge clk);
          check("bp_in_ready", m_rdy_in, 0);
          check("bp_sym_valid", m_sv, 1);
        end
      end else begin
        d_ready = 1'b1;
      end
      if (abort_bits >= 0 && data_out >= 10 && bits_acc >= abort_bits) break;
      @(posedge clk); #1;
      cyc++;
    end
    d_valid = 1'b0;
    d_ready = 1'b1;
    if (abort_bits < 0) check("frame_done_seen", fd_count, 1);
    else check("abort_point_reached", (data_out >= 10), 1);
  endtask

  task automatic check_nominal(input string tag);
    int n10;
    n10 = 0;
    check({tag, "_total_syms"}, sym_count, 39);
    check({tag, "_bits"}, bits_acc, 64);
    check({tag, "_frame_done"}, fd_count, 1);
    for (int k = 0; k < 4; k++)
      check({tag, "_preamble"}, out_log[k], (k % 2 == 1) ? 3'b111 : 3'b001);
    check({tag, "_pilot1"}, out_log[12], 3'b001);
    check({tag, "_pilot2"}, out_log[21], 3'b001);
    check({tag, "_pilot3"}, out_log[30], 3'b001);
    for (int i = 0; i < 39; i++) if (out_log[i] == 3'b100) n10++;
    check({tag, "_data_10_count"}, n10, 32);
  endtask

  initial begin
    int ndiff, npil;
    rst_n = 1'b0; start0 = 1'b0; start1 = 1'b0; sel = 1'b0;
    d_bit = 1'b0; d_valid = 1'b0; d_ready = 1'b1;
    frame_f = 32; sym_count = 0; bits_acc = 0; dcount = 0; data_out = 0; fd_count = 0;
    half = 1'b0; half_bit = 1'b0; active = 1'b0; prev_hold = 1'b0; prev_sym = '0;
    fork monitor(); join_none

    #3;
    check("rst_sym_valid", b0.sym_valid, 0);
    check("rst_in_ready", b0.in_ready, 0);
    check("rst_busy", busy0, 0);
    check("rst_frame_done", fd0, 0);
    check("rst_sym_bits", {b0.sym_bit1, b0.sym_bit2, b0.sym_is_pilot}, 0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;

    // Nominal, then a back-to-back frame with backpressure.
    run_frame(1'b0, 32, 0, 1, -1, -1);
    check_nominal("nom");
    for (int i = 0; i < 64; i++) nom_log[i] = out_log[i];
    run_frame(1'b0, 32, 0, 1, 12, -1);
    check_nominal("bp");
    ndiff = 0;
    for (int i = 0; i < 39; i++) if (out_log[i] != nom_log[i]) ndiff++;
    check("bp_vs_nominal_diffs", ndiff, 0);

    // Sparse input, pattern pairs (0,1),(0,0),(1,1),(0,1).
    run_frame(1'b0, 32, 1, 3, -1, -1);
    check("sparse_total", sym_count, 39);
    check("sparse_bits", bits_acc, 64);
    check("sparse_d1", out_log[4], 3'b010);
    check("sparse_d2", out_log[5], 3'b000);
    check("sparse_d3", out_log[6], 3'b110);
    check("sparse_d4", out_log[7], 3'b010);
    check("sparse_pilot1", out_log[12], 3'b001);

    // Short frame: one pilot only.
    run_frame(1'b1, 16, 0, 1, -1, -1);
    npil = 0;
    for (int i = 0; i < 21; i++) if (out_log[i][0]) npil++;
    check("f16_total", sym_count, 21);
    check("f16_bits", bits_acc, 32);
    check("f16_pilot", out_log[12], 3'b001);
    check("f16_last_data", out_log[20], 3'b100);
    check("f16_pilot_flags", npil, 5);

    // Abort mid-frame with a half pair held, then restart.
    repeat (2) @(posedge clk);
    #1;
    run_frame(1'b0, 32, 0, 1, -1, 21);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_sym_valid", b0.sym_valid, 0);
    check("abort_busy", busy0, 0);
    check("abort_in_ready", b0.in_ready, 0);
    check("abort_frame_done", fd0, 0);
    check("abort_sym_bits", {b0.sym_bit1, b0.sym_bit2, b0.sym_is_pilot}, 0);
    check("abort_no_done_seen", fd_count, 0);
    check("abort_half_held", bits_acc % 2, 1);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_frame(1'b0, 32, 0, 1, -1, -1);
    check_nominal("restart");
    check("restart_first", out_log[0], 3'b001);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
